nh_lcd_data_reader: RTL and testbench
=====================================

NH_LCD_DATA_READER -- requirements
Module: nh_lcd_data_reader

Interface
REQ-001 The module SHALL have one parameter: DATAS_WIDTH, default 24, FIFO write-data width; pixel packed in bits [23:0].
REQ-002 The module SHALL have one clock; reset is synchronous and active-high. Ports, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- debug  out  32  status: [0] i_enable, [1] o_cmd_mode, [2] o_write, [3] o_read, [7:4] state, [8] o_data_out_en, rest 0
- i_enable  in  1  rising edge starts a frame read
- i_num_pixels  in  32  pixels to read per frame
- i_enable_tearing  in  1  1 = wait for i_tearing_effect before the command
- i_fifo_rdy  in  2  ping-pong FIFO write-side buffer ready
- o_fifo_act  out  2  buffer activate, one-hot
- i_fifo_size  in  24  depth of the granted buffer
- o_fifo_stb  out  1  write strobe, one cycle per pixel
- o_fifo_data  out  DATAS_WIDTH  {red, green, blue}, zero-extended
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse at end of frame
- o_cmd_mode  out  1  0 = command byte, 1 = data
- o_data_out  out  8  bus drive value
- i_data_in  in  8  bus read value
- o_write  out  1  active-high write strobe
- o_read  out  1  active-high read strobe
- o_data_out_en  out  1  1 = module drives the bus
- i_tearing_effect  in  1  LCD TE pin

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_TE, WRITE_CMD, CMD_HOLD, TURNAROUND, READ_DUMMY, WAIT_FIFO, READ_RED, READ_GREEN, READ_BLUE, PUSH and DONE.
REQ-004 IDLE SHALL leave IDLE only on an i_enable 0->1 edge (registered previous value) with i_num_pixels != 0; if i_num_pixels == 0 it SHALL stay in IDLE with no bus activity.
REQ-005 From IDLE, the FSM SHALL go to WAIT_TE if i_enable_tearing = 1, else to WRITE_CMD; WAIT_TE SHALL advance to WRITE_CMD on the first cycle i_tearing_effect = 1.
REQ-006 WRITE_CMD (1 cycle) SHALL drive o_cmd_mode=0, o_write=1, o_data_out=`CMD_START_MEM_READ (0x2E).
REQ-007 CMD_HOLD (1 cycle) SHALL drive o_cmd_mode=0, o_write=0, with o_data_out held.
REQ-008 TURNAROUND (1 cycle) SHALL drive o_data_out_en=0.
REQ-009 o_data_out_en SHALL stay 0 from TURNAROUND until DONE.
REQ-010 Each byte-read state SHALL last 3 cycles: o_read=1, o_read=1, o_read=0.
REQ-011 i_data_in SHALL be captured on the clock edge that ends the second o_read=1 cycle.
REQ-012 The READ_DUMMY byte SHALL be discarded; READ_DUMMY SHALL then go to WAIT_FIFO.
REQ-013 WAIT_FIFO SHALL hold the bus idle (o_read=0, o_write=0) until o_fifo_act != 0, then go to READ_RED, READ_GREEN, READ_BLUE, PUSH in sequence.
REQ-014 FIFO acquire: when o_busy=1, o_fifo_act=0 and i_fifo_rdy != 0, the module SHALL set o_fifo_act[0] if i_fifo_rdy[0], else o_fifo_act[1].
REQ-015 On acquire, the module SHALL latch i_fifo_size and clear the buffer count.
REQ-016 PUSH (1 cycle) SHALL assert o_fifo_stb=1 with o_fifo_data = {R,G,B} and increment the 32-bit pixel count and the 24-bit buffer count.
REQ-017 After PUSH, the FSM SHALL test the following in priority order:
- pixel count == i_num_pixels: release o_fifo_act, go to DONE
- buffer count == latched size: release o_fifo_act, go to WAIT_FIFO
- otherwise: go directly to READ_RED
REQ-018 Steady-state throughput SHALL be 10 cycles per pixel.
REQ-019 i_enable low observed in WAIT_FIFO SHALL abort the frame: the partial buffer is released (committed) and the FSM goes to DONE; a pixel already started SHALL always complete.
REQ-020 DONE (1 cycle) SHALL pulse o_done=1, restore o_data_out_en=1, and go to IDLE; the pixel count SHALL clear on the next start.
REQ-021 o_busy SHALL be 1 in every state except IDLE.
REQ-022 o_cmd_mode SHALL be 1 in every state except WRITE_CMD and CMD_HOLD.
REQ-023 i_num_pixels SHALL be latched at start; changes mid-frame SHALL be ignored.

Reset
REQ-024 On rst=1 at a clock edge, the module SHALL force:
- state IDLE; counters and the captured byte 0
- o_fifo_act=0, o_fifo_stb=0, o_fifo_data=0
- o_write=0, o_read=0, o_cmd_mode=1, o_data_out_en=1, o_data_out=0x2E
- o_busy=0, o_done=0
REQ-025 Reset mid-frame SHALL abandon the frame at once; no o_done pulse; the partial buffer is not committed.

Verification
REQ-026 i_num_pixels=2, tearing off, i_fifo_rdy=2'b01, size 16, LCD returns 0xFF,0x12,0x34,0x56,0xAB,0xCD,0xEF -> one 0x2E write, 7 byte reads, FIFO gets 0x123456 then 0xABCDEF, act released, o_done pulses once.
REQ-027 Tearing on, i_tearing_effect low for 50 cycles -> no o_write until TE high; WRITE_CMD exactly 1 cycle after TE seen.
REQ-028 i_num_pixels=5, size 2, rdy toggling 01/10 with 20-cycle gaps -> pushes 2,2,1 on act 01,10,01; o_read stays 0 during the gaps; 5 pixels total in order.
REQ-029 i_num_pixels=0 with an enable edge -> no strobes, o_busy stays 0; i_enable held high after a frame -> no second frame until i_enable falls and rises again.
REQ-030 rst asserted during READ_GREEN -> next cycle all outputs at reset values and act=0; a new enable edge restarts from WRITE_CMD.

Source files
------------

// File: rtl/nh_lcd_data_reader.sv
// Reads a frame of RGB pixels from an LCD controller over an 8-bit parallel bus
// (memory-read command, dummy byte, then R/G/B triplets) and pushes them into a ping-pong FIFO.
module nh_lcd_data_reader #(
    parameter int DATAS_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            debug,
    input  logic                   i_enable,
    input  logic [31:0]            i_num_pixels,
    input  logic                   i_enable_tearing,
    input  logic [1:0]             i_fifo_rdy,
    output logic [1:0]             o_fifo_act,
    input  logic [23:0]            i_fifo_size,
    output logic                   o_fifo_stb,
    output logic [DATAS_WIDTH-1:0] o_fifo_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_cmd_mode,
    output logic [7:0]             o_data_out,
    input  logic [7:0]             i_data_in,
    output logic                   o_write,
    output logic                   o_read,
    output logic                   o_data_out_en,
    input  logic                   i_tearing_effect
);

    localparam logic [7:0] CMD_START_MEM_READ = 8'h2E;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WAIT_TE    = 4'd1,
        WRITE_CMD  = 4'd2,
        CMD_HOLD   = 4'd3,
        TURNAROUND = 4'd4,
        READ_DUMMY = 4'd5,
        WAIT_FIFO  = 4'd6,
        READ_RED   = 4'd7,
        READ_GREEN = 4'd8,
        READ_BLUE  = 4'd9,
        PUSH       = 4'd10,
        DONE       = 4'd11
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  phase_reg;
    logic        enable_prev_reg;
    logic [31:0] num_pixels_reg;
    logic [31:0] pixel_count_reg;
    logic [23:0] buf_count_reg;
    logic [23:0] buf_size_reg;
    logic [7:0]  red_reg, green_reg, blue_reg;
    logic [1:0]  fifo_act_reg;

    logic        start;
    logic        read_state;
    logic        byte_last;
    logic        release_act;
    logic        acquire;
    logic [31:0] pixel_count_inc;
    logic [23:0] buf_count_inc;

    always_comb begin
        read_state      = (state_reg == READ_DUMMY) || (state_reg == READ_RED) ||
                          (state_reg == READ_GREEN) || (state_reg == READ_BLUE);
        byte_last       = read_state && (phase_reg == 2'd2);
        start           = (state_reg == IDLE) && i_enable && !enable_prev_reg &&
                          (i_num_pixels != 32'd0);
        pixel_count_inc = pixel_count_reg + 32'd1;
        buf_count_inc   = buf_count_reg + 24'd1;
        state_next      = state_reg;
        release_act     = 1'b0;

        case (state_reg)
            IDLE:       if (start) state_next = i_enable_tearing ? WAIT_TE : WRITE_CMD;
            WAIT_TE:    if (i_tearing_effect) state_next = WRITE_CMD;
            WRITE_CMD:  state_next = CMD_HOLD;
            CMD_HOLD:   state_next = TURNAROUND;
            TURNAROUND: state_next = READ_DUMMY;
            READ_DUMMY: if (byte_last) state_next = WAIT_FIFO;
            WAIT_FIFO: begin
                // Abort takes priority so a partially filled buffer is committed right away.
                if (!i_enable) begin
                    release_act = 1'b1;
                    state_next  = DONE;
                end else if (fifo_act_reg != 2'b00) begin
                    state_next = READ_RED;
                end
            end
            READ_RED:   if (byte_last) state_next = READ_GREEN;
            READ_GREEN: if (byte_last) state_next = READ_BLUE;
            READ_BLUE:  if (byte_last) state_next = PUSH;
            PUSH: begin
                if (pixel_count_inc == num_pixels_reg) begin
                    release_act = 1'b1;
                    state_next  = DONE;
                end else if (buf_count_inc == buf_size_reg) begin
                    release_act = 1'b1;
                    state_next  = WAIT_FIFO;
                end else begin
                    state_next = READ_RED;
                end
            end
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase

        // No grab while finishing, otherwise a buffer would stay held after the frame ends.
        acquire = (state_reg != IDLE) && (state_reg != DONE) && (fifo_act_reg == 2'b00) &&
                  (i_fifo_rdy != 2'b00) && !release_act;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            phase_reg       <= 2'd0;
            enable_prev_reg <= 1'b0;
            num_pixels_reg  <= 32'd0;
            pixel_count_reg <= 32'd0;
            buf_count_reg   <= 24'd0;
            buf_size_reg    <= 24'd0;
            red_reg         <= 8'd0;
            green_reg       <= 8'd0;
            blue_reg        <= 8'd0;
            fifo_act_reg    <= 2'b00;
        end else begin
            state_reg       <= state_next;
            enable_prev_reg <= i_enable;
            phase_reg       <= (read_state && phase_reg != 2'd2) ? phase_reg + 2'd1 : 2'd0;

            if (start) begin
                num_pixels_reg  <= i_num_pixels;
                pixel_count_reg <= 32'd0;
            end

            if (state_reg == PUSH) begin
                pixel_count_reg <= pixel_count_inc;
                buf_count_reg   <= buf_count_inc;
            end

            if (release_act) begin
                fifo_act_reg <= 2'b00;
            end else if (acquire) begin
                fifo_act_reg  <= i_fifo_rdy[0] ? 2'b01 : 2'b10;
                buf_size_reg  <= i_fifo_size;
                buf_count_reg <= 24'd0;
            end

            // Sample the bus on the edge that ends the second strobed cycle.
            if (read_state && phase_reg == 2'd1) begin
                case (state_reg)
                    READ_RED:   red_reg   <= i_data_in;
                    READ_GREEN: green_reg <= i_data_in;
                    READ_BLUE:  blue_reg  <= i_data_in;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        o_fifo_data        = '0;
        o_fifo_data[23:0]  = {red_reg, green_reg, blue_reg};
    end

    assign o_fifo_act    = fifo_act_reg;
    assign o_fifo_stb    = (state_reg == PUSH);
    assign o_busy        = (state_reg != IDLE);
    assign o_done        = (state_reg == DONE);
    assign o_cmd_mode    = !((state_reg == WRITE_CMD) || (state_reg == CMD_HOLD));
    assign o_write       = (state_reg == WRITE_CMD);
    assign o_read        = read_state && (phase_reg != 2'd2);
    assign o_data_out    = CMD_START_MEM_READ;
    assign o_data_out_en = (state_reg == IDLE) || (state_reg == WAIT_TE) ||
                           (state_reg == WRITE_CMD) || (state_reg == CMD_HOLD) ||
                           (state_reg == DONE);

    assign debug = {23'd0, o_data_out_en, state_reg, o_read, o_write, o_cmd_mode, i_enable};

endmodule

// File: tb/tb_nh_lcd_data_reader.sv
// Directed bench for nh_lcd_data_reader: an LCD byte-source model, a ping-pong FIFO
// driven from the stimulus sequence, and a negedge monitor that logs strobes and pushes.
module tb_nh_lcd_data_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] debug;
    logic        i_enable;
    logic [31:0] i_num_pixels;
    logic        i_enable_tearing;
    logic [1:0]  i_fifo_rdy;
    logic [1:0]  o_fifo_act;
    logic [23:0] i_fifo_size;
    logic        o_fifo_stb;
    logic [23:0] o_fifo_data;
    logic        o_busy;
    logic        o_done;
    logic        o_cmd_mode;
    logic [7:0]  o_data_out;
    logic [7:0]  i_data_in;
    logic        o_write;
    logic        o_read;
    logic        o_data_out_en;
    logic        i_tearing_effect;

    always #5 clk = ~clk;

    nh_lcd_data_reader #(.DATAS_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .debug(debug), .i_enable(i_enable),
        .i_num_pixels(i_num_pixels), .i_enable_tearing(i_enable_tearing),
        .i_fifo_rdy(i_fifo_rdy), .o_fifo_act(o_fifo_act), .i_fifo_size(i_fifo_size),
        .o_fifo_stb(o_fifo_stb), .o_fifo_data(o_fifo_data), .o_busy(o_busy),
        .o_done(o_done), .o_cmd_mode(o_cmd_mode), .o_data_out(o_data_out),
        .i_data_in(i_data_in), .o_write(o_write), .o_read(o_read),
        .o_data_out_en(o_data_out_en), .i_tearing_effect(i_tearing_effect)
    );

    int errors = 0;
    int checks = 0;

    // Monitor state (written only by the monitor process)
    int write_cnt = 0, read_cnt = 0, busy_cnt = 0, done_cnt = 0, stb_cnt = 0, cyc = 0;
    logic [7:0]  last_wdata = 8'h00;
    logic [23:0] push_data[$];
    logic [1:0]  push_act[$];
    int          push_cyc[$];

    // LCD model: each byte is presented for the two strobed cycles of its read
    logic [7:0]  lcd_bytes [0:63];
    int          lcd_base = 0;
    logic [31:0] rd_off;
    assign rd_off    = 32'(read_cnt - lcd_base - 1);
    assign i_data_in = lcd_bytes[rd_off[6:1]];

    always @(negedge clk) begin
        if (o_write) begin
            write_cnt  <= write_cnt + 1;
            last_wdata <= o_data_out;
        end
        if (o_read) read_cnt <= read_cnt + 1;
        if (o_busy) busy_cnt <= busy_cnt + 1;
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_fifo_stb) begin
            stb_cnt <= stb_cnt + 1;
            push_data.push_back(o_fifo_data);
            push_act.push_back(o_fifo_act);
            push_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] get_push(input int sel, input int idx);
        if (idx >= push_data.size()) return 32'hDEADBEEF;
        case (sel)
            0:       return {8'd0, push_data[idx]};
            1:       return {30'd0, push_act[idx]};
            default: return 32'(push_cyc[idx]);
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_act(input string tag, input logic [1:0] val, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_fifo_act == val) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic start_frame(input logic [31:0] num);
        i_num_pixels = num;
        i_enable     = 1'b0;
        @(negedge clk);
        i_enable = 1'b1;
    endtask

    task automatic load_pixels(input int n);
        lcd_base     = read_cnt;
        lcd_bytes[0] = 8'h00;
        for (int i = 0; i < n; i++) begin
            lcd_bytes[1 + 3*i] = 8'(8'h10 + i);
            lcd_bytes[2 + 3*i] = 8'(8'h20 + i);
            lcd_bytes[3 + 3*i] = 8'(8'h30 + i);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, d0, b0, s0, r0, p0;
        bit found;
        for (int i = 0; i < 64; i++) lcd_bytes[i] = 8'h00;
        rst = 1'b1; i_enable = 1'b0; i_num_pixels = 32'd0; i_enable_tearing = 1'b0;
        i_fifo_rdy = 2'b00; i_fifo_size = 24'd0; i_tearing_effect = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_act", 32'(o_fifo_act), 32'd0);
        check("rst_data_out", 32'(o_data_out), 32'h2E);
        check("rst_cmd_mode", 32'(o_cmd_mode), 32'd1);
        check("rst_out_en", 32'(o_data_out_en), 32'd1);
        check("rst_fifo_data", 32'(o_fifo_data), 32'd0);
        check("rst_debug", debug, 32'h0000_0102);

        // Two-pixel frame, single buffer
        lcd_base = read_cnt;
        lcd_bytes[0] = 8'hFF; lcd_bytes[1] = 8'h12; lcd_bytes[2] = 8'h34; lcd_bytes[3] = 8'h56;
        lcd_bytes[4] = 8'hAB; lcd_bytes[5] = 8'hCD; lcd_bytes[6] = 8'hEF;
        w0 = write_cnt; d0 = done_cnt; p0 = push_data.size();
        i_fifo_rdy = 2'b01; i_fifo_size = 24'd16;
        start_frame(32'd2);
        wait_done("t1_done", 200);
        tick(3);
        check("t1_writes", 32'(write_cnt - w0), 32'd1);
        check("t1_cmd_byte", 32'(last_wdata), 32'h2E);
        check("t1_read_cycles", 32'(read_cnt - lcd_base), 32'd14);
        check("t1_push_count", 32'(push_data.size() - p0), 32'd2);
        check("t1_px0", get_push(0, p0), 32'h0012_3456);
        check("t1_px1", get_push(0, p0 + 1), 32'h00AB_CDEF);
        check("t1_act0", get_push(1, p0), 32'd1);
        check("t1_px_spacing", get_push(2, p0 + 1) - get_push(2, p0), 32'd10);
        check("t1_act_released", 32'(o_fifo_act), 32'd0);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Tearing-effect gating
        i_enable_tearing = 1'b1;
        load_pixels(1);
        w0 = write_cnt; p0 = push_data.size();
        start_frame(32'd1);
        tick(50);
        check("t2_no_write_before_te", 32'(write_cnt - w0), 32'd0);
        check("t2_state_wait_te", 32'(debug[7:4]), 32'd1);
        i_tearing_effect = 1'b1;
        check("t2_write_low_at_te", 32'(o_write), 32'd0);
        @(negedge clk);
        i_tearing_effect = 1'b0;
        check("t2_write_after_te", 32'(o_write), 32'd1);
        check("t2_state_write_cmd", 32'(debug[7:4]), 32'd2);
        tick(1);
        check("t2_write_one_cycle", 32'(o_write), 32'd0);
        wait_done("t2_done", 200);
        tick(2);
        check("t2_px0", get_push(0, p0), 32'h0010_2030);
        i_enable_tearing = 1'b0;

        // Five pixels through two-deep ping-pong buffers with gaps
        load_pixels(5);
        p0 = push_data.size();
        i_fifo_rdy = 2'b01; i_fifo_size = 24'd2;
        start_frame(32'd5);
        wait_act("t3_act_a", 2'b01, 20);
        i_fifo_rdy = 2'b00;
        wait_act("t3_rel_a", 2'b00, 100);
        r0 = read_cnt;
        tick(20);
        check("t3_gap1_no_read", 32'(read_cnt - r0), 32'd0);
        i_fifo_rdy = 2'b10;
        wait_act("t3_act_b", 2'b10, 5);
        i_fifo_rdy = 2'b00;
        wait_act("t3_rel_b", 2'b00, 100);
        r0 = read_cnt;
        tick(20);
        check("t3_gap2_no_read", 32'(read_cnt - r0), 32'd0);
        i_fifo_rdy = 2'b01;
        wait_act("t3_act_c", 2'b01, 5);
        i_fifo_rdy = 2'b00;
        wait_done("t3_done", 100);
        tick(2);
        check("t3_push_count", 32'(push_data.size() - p0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_px%0d", i), get_push(0, p0 + i), 32'h0010_2030 + 32'h0001_0101 * i);
            check($sformatf("t3_act%0d", i), get_push(1, p0 + i), (i == 2 || i == 3) ? 32'd2 : 32'd1);
        end

        // Abort while waiting for a buffer commits the partial frame
        load_pixels(5);
        p0 = push_data.size();
        i_fifo_rdy = 2'b01;
        start_frame(32'd5);
        wait_act("t4_act", 2'b01, 20);
        i_fifo_rdy = 2'b00;
        wait_act("t4_rel", 2'b00, 100);
        tick(3);
        i_enable = 1'b0;
        wait_done("t4_abort_done", 10);
        tick(2);
        check("t4_pushes", 32'(push_data.size() - p0), 32'd2);
        check("t4_act_idle", 32'(o_fifo_act), 32'd0);

        // Zero-pixel request and held-high enable
        b0 = busy_cnt; s0 = stb_cnt;
        start_frame(32'd0);
        tick(20);
        check("t5_zero_busy", 32'(busy_cnt - b0), 32'd0);
        check("t5_zero_stb", 32'(stb_cnt - s0), 32'd0);
        load_pixels(1);
        i_fifo_rdy = 2'b01; i_fifo_size = 24'd16;
        start_frame(32'd1);
        wait_done("t5_frame_done", 200);
        tick(2);
        b0 = busy_cnt; d0 = done_cnt;
        tick(30);
        check("t5_held_high_busy", 32'(busy_cnt - b0), 32'd0);
        check("t5_held_high_done", 32'(done_cnt - d0), 32'd0);
        load_pixels(1);
        start_frame(32'd1);
        wait_done("t5_second_frame", 200);
        tick(2);

        // Reset in the middle of a green read
        load_pixels(3);
        start_frame(32'd3);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (debug[7:4] == 4'd8) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reached_green", 32'(found), 32'd1);
        d0 = done_cnt;
        rst = 1'b1;
        i_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", 32'(o_busy), 32'd0);
        check("t6_act", 32'(o_fifo_act), 32'd0);
        check("t6_read", 32'(o_read), 32'd0);
        check("t6_write", 32'(o_write), 32'd0);
        check("t6_stb", 32'(o_fifo_stb), 32'd0);
        check("t6_fifo_data", 32'(o_fifo_data), 32'd0);
        check("t6_data_out", 32'(o_data_out), 32'h2E);
        check("t6_debug", debug, 32'h0000_0102);
        tick(3);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        load_pixels(3);
        i_fifo_rdy = 2'b01;
        start_frame(32'd3);
        @(negedge clk);
        check("t6_restart_write_cmd", 32'(debug[7:4]), 32'd2);
        wait_done("t6_restart_done", 300);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
